// File: rtl/ramwriter.sv
// Burst RAM writer: latches a base address and up to NB data bytes, then
// emits one registered byte write per cycle followed by a single done pulse.
module ramwriter #(
  parameter int AW = 16,
  parameter int NB = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   add,
  input  logic [3:0]      len,
  input  logic [8*NB-1:0] d,
  output logic            we,
  output logic [AW-1:0]   adq,
  output logic [7:0]      q,
  output logic            kp,
  output logic            done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] NBL = 4'(NB);

  logic [1:0]      state;
  logic [AW-1:0]   base_l;
  logic [8*NB-1:0] data_l;
  logic [3:0]      len_l;
  logic [3:0]      cnt;
  logic [3:0]      len_c;
  logic [8*NB-1:0] data_sh;

  always_comb begin
    len_c   = (len > NBL) ? NBL : len;
    data_sh = data_l >> {cnt, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base_l <= '0;
      data_l <= '0;
      len_l  <= '0;
      cnt    <= '0;
      we     <= 1'b0;
      adq    <= '0;
      q      <= '0;
      kp     <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we   <= 1'b0;
          kp   <= 1'b0;
          done <= 1'b0;
          // kp is still high in the cycle done is shown, so a start there is ignored
          if (start && !kp) begin
            base_l <= add;
            data_l <= d;
            len_l  <= len_c;
            cnt    <= '0;
            state  <= (len_c == 4'd0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          we   <= 1'b1;
          kp   <= 1'b1;
          done <= 1'b0;
          adq  <= base_l + AW'(cnt);
          q    <= data_sh[7:0];
          cnt  <= cnt + 4'd1;
          if (cnt == len_l - 4'd1)
            state <= DONE;
        end
        DONE: begin
          we    <= 1'b0;
          kp    <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          we    <= 1'b0;
          kp    <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramwriter.sv
// Self-checking bench for ramwriter: per-cycle comparison against a burst-level
// model, plus literal checks on directed bursts.
module tb_ramwriter;

  localparam int AW = 16;
  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   add;
  logic [3:0]      len;
  logic [8*NB-1:0] d;
  logic            we;
  logic [AW-1:0]   adq;
  logic [7:0]      q;
  logic            kp;
  logic            done;

  always #5 clk = ~clk;

  ramwriter #(.AW(AW), .NB(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .add(add), .len(len), .d(d),
    .we(we), .adq(adq), .q(q), .kp(kp), .done(done)
  );

  int checks = 0;
  int passes = 0;

  // Burst-level model: one accepted burst described by its accept edge t0,
  // clamped length L, base address and data word.
  int              cyc = 0;
  bit              active = 0;
  int              t0 = 0;
  int              L = 0;
  logic [AW-1:0]   ba;
  logic [8*NB-1:0] bd;
  logic            e_we, e_kp, e_done;
  logic [AW-1:0]   e_adq = '0;
  logic [7:0]      e_q = '0;

  int              wcount = 0;
  int              done_cyc = -1;
  logic [7:0]      mem [logic [AW-1:0]];

  always @(posedge clk) begin
    int k;
    logic [8*NB-1:0] tmp;
    cyc = cyc + 1;
    if (rst) begin
      active = 0;
      e_adq  = '0;
      e_q    = '0;
    end else begin
      if (active && cyc > t0 + L + 2) active = 0;
      if (!active && start) begin
        t0 = cyc;
        L  = (int'(len) > NB) ? NB : int'(len);
        ba = add;
        bd = d;
        active = 1;
      end
    end
    k      = cyc - t0;
    e_we   = active && k >= 1 && k <= L;
    e_done = active && k == L + 1;
    e_kp   = active && k >= 1 && k <= L + 1;
    if (e_we) begin
      e_adq = ba + AW'(k - 1);
      tmp   = bd >> (8 * (k - 1));
      e_q   = tmp[7:0];
    end
    #1;
    checks = checks + 1;
    if ({we, kp, done, adq, q} === {e_we, e_kp, e_done, e_adq, e_q})
      passes = passes + 1;
    else
      $display("FAIL cycle%0d: got we=%b kp=%b done=%b adq=%h q=%h, want we=%b kp=%b done=%b adq=%h q=%h",
               cyc, we, kp, done, adq, q, e_we, e_kp, e_done, e_adq, e_q);
    if (we === 1'b1) begin
      mem[adq] = q;
      wcount   = wcount + 1;
    end
    if (done === 1'b1) done_cyc = cyc;
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks = checks + 1;
    if (got == exp) passes = passes + 1;
    else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
  endtask

  task automatic go(input logic [AW-1:0] a, input logic [3:0] n,
                    input logic [8*NB-1:0] dd, output int t);
    @(negedge clk);
    start = 1'b1; add = a; len = n; d = dd;
    t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    add = AW'($urandom);
    d = {$urandom, $urandom};
    len = 4'($urandom);
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t, w0;
    rst = 1'b1; start = 1'b0; add = '0; len = '0; d = '0;
    idle_wait(2);
    chk("reset_outputs", {we, kp, done, adq, q}, 0);
    rst = 1'b0;
    idle_wait(2);

    // 8-byte burst at 0x0100
    mem.delete(); done_cyc = -1; w0 = wcount;
    go(16'h0100, 4'd8, 64'h0807060504030201, t);
    idle_wait(12);
    chk("b8_writes", wcount - w0, 8);
    for (int i = 0; i < 8; i++) chk("b8_byte", mem[AW'(16'h0100 + i)], i + 1);
    chk("b8_done_lat", done_cyc - t, 9);

    // address wrap
    mem.delete(); done_cyc = -1; w0 = wcount;
    go(16'hFFFE, 4'd4, 64'h44332211, t);
    idle_wait(10);
    chk("wrap_writes", wcount - w0, 4);
    chk("wrap_fffe", mem[16'hFFFE], 8'h11);
    chk("wrap_ffff", mem[16'hFFFF], 8'h22);
    chk("wrap_0000", mem[16'h0000], 8'h33);
    chk("wrap_0001", mem[16'h0001], 8'h44);
    chk("wrap_done_lat", done_cyc - t, 5);

    // len=0 and len=1
    done_cyc = -1; w0 = wcount;
    go(16'h1234, 4'd0, 64'hAA, t);
    idle_wait(6);
    chk("len0_writes", wcount - w0, 0);
    chk("len0_done_lat", done_cyc - t, 1);
    mem.delete(); done_cyc = -1; w0 = wcount;
    go(16'h2222, 4'd1, 64'h9A5B, t);
    idle_wait(6);
    chk("len1_writes", wcount - w0, 1);
    chk("len1_byte", mem[16'h2222], 8'h5B);
    chk("len1_done_lat", done_cyc - t, 2);

    // start held with changing inputs through burst and done cycle
    mem.delete(); done_cyc = -1; w0 = wcount;
    go(16'h0300, 4'd8, 64'h1817161514131211, t);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      add = AW'($urandom); d = {$urandom, $urandom}; len = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    idle_wait(12);
    chk("hold_writes", wcount - w0, 8);
    for (int i = 0; i < 8; i++) chk("hold_byte", mem[AW'(16'h0300 + i)], 8'h11 + i);

    // asynchronous reset after the 3rd write
    done_cyc = -1; w0 = wcount;
    go(16'h2000, 4'd8, 64'hF0E0D0C0B0A09080, t);
    idle_wait(3);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", {we, kp, done, adq, q}, 0);
    active = 0; e_adq = '0; e_q = '0;
    #1 rst = 1'b0;
    idle_wait(12);
    chk("abort_writes", wcount - w0, 3);
    chk("abort_no_done", done_cyc, -1);
    w0 = wcount;
    go(16'h2100, 4'd8, 64'h0123456789ABCDEF, t);
    idle_wait(12);
    chk("after_abort_writes", wcount - w0, 8);
    chk("after_abort_done_lat", done_cyc - t, 9);

    // length clamp
    done_cyc = -1; w0 = wcount;
    go(16'h4000, 4'd12, 64'hCAFEBABEDEADBEEF, t);
    idle_wait(14);
    chk("clamp_writes", wcount - w0, 8);
    chk("clamp_done_lat", done_cyc - t, 9);

    // random bursts, sometimes with start held afterwards
    for (int n = 0; n < 40; n++) begin
      go(AW'($urandom), 4'($urandom), {$urandom, $urandom}, t);
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        repeat ($urandom_range(1, 12)) begin
          add = AW'($urandom); d = {$urandom, $urandom}; len = 4'($urandom);
          @(negedge clk);
        end
        start = 1'b0;
      end
      idle_wait(25);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
